// File: rtl/game_pkg.sv
// Shared definitions for the Simon sequence game: FSM state encoding and
// the Galois LFSR tap constant with its next-value helper.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GEN      = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_INPUT    = 3'd4,
    ST_LVL_DONE = 3'd5,
    ST_WIN      = 3'd6,
    ST_LOSE     = 3'd7
  } game_state_e;

  // Galois feedback mask applied when the bit shifted out is 1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Shift-right Galois step.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    logic [7:0] shifted;
    shifted = cur >> 1;
    return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/game_lfsr8.sv
// Free-running 8-bit Galois LFSR. It never pauses, so the pattern a game
// gets depends on when the player presses start.
module game_lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next LFSR value, computed every cycle regardless of game state.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR register: reloads the seed on reset, otherwise advances each cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/simon_sequence_game.sv
// Simon-style memory game core: fills a pattern RAM from an LFSR, plays
// back growing prefixes of it on the LEDs and checks the player's presses.
// Optional per-symbol input timeout enabled by defining GAME_TIMEOUT_EN.
module simon_sequence_game
  import game_pkg::*;
#(
  parameter int unsigned N_BUTTONS   = 4,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned SHOW_CYCLES = 25,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter logic [7:0]  LFSR_SEED   = 8'h5A
) (
  input  logic                 osc_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_BUTTONS-1:0] button,
  output logic [N_BUTTONS-1:0] led,
  output logic                 busy,
  output logic [7:0]           level,
  output logic [7:0]           correct_count,
  output logic                 win,
  output logic                 lose
);

  localparam int unsigned SYM_W = $clog2(N_BUTTONS);
  localparam int unsigned IW    = $clog2(MAX_LEN);
  localparam int unsigned SW    = $clog2(SHOW_CYCLES + 1);

  localparam logic [7:0]    LAST_IDX  = 8'(MAX_LEN - 1);
  localparam logic [7:0]    MAX_LVL   = 8'(MAX_LEN);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);

  game_state_e state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  level_q, level_d;
  logic [7:0]  cc_q, cc_d;
  logic [SW-1:0] show_q, show_d;
  logic [N_BUTTONS-1:0] button_q;
  logic [N_BUTTONS-1:0] press;
  logic [N_BUTTONS-1:0] exp_onehot;
  logic [SYM_W-1:0] ram_q [MAX_LEN];
  logic [SYM_W-1:0] cur_sym;
  logic ram_we;
  logic [7:0] lfsr;

`ifdef GAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  game_lfsr8 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i  (osc_clk),
    .reset_i(reset),
    .lfsr_o (lfsr)
  );

  assign press      = button & ~button_q;
  assign cur_sym    = ram_q[idx_q[IW-1:0]];
  assign exp_onehot = N_BUTTONS'(1) << cur_sym;

  // Pattern RAM: one LFSR symbol stored per GEN cycle at the current index.
  always_ff @(posedge osc_clk) begin
    if (ram_we) begin
      ram_q[idx_q[IW-1:0]] <= lfsr[SYM_W-1:0];
    end
  end

  // State, counters and button history register.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      level_q  <= '0;
      cc_q     <= '0;
      show_q   <= '0;
      button_q <= '0;
`ifdef GAME_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      level_q  <= level_d;
      cc_q     <= cc_d;
      show_q   <= show_d;
      button_q <= button;
`ifdef GAME_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  // Game sequencing: next state and next counter values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    level_d = level_q;
    cc_d    = cc_q;
    show_d  = show_q;
    ram_we  = 1'b0;
`ifdef GAME_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          state_d = ST_GEN;
          idx_d   = '0;
          level_d = '0;
          cc_d    = '0;
        end
      end
      ST_GEN: begin
        ram_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          level_d = 8'd1;
          show_d  = '0;
          state_d = ST_SHOW_ON;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      ST_SHOW_ON: begin
        if (show_q == SHOW_LAST) begin
          show_d  = '0;
          state_d = ST_SHOW_OFF;
        end else begin
          show_d = show_q + SW'(1);
        end
      end
      ST_SHOW_OFF: begin
        if (show_q == SHOW_LAST) begin
          show_d = '0;
          if (idx_q < level_q - 8'd1) begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_SHOW_ON;
          end else begin
            idx_d   = '0;
            cc_d    = '0;
            state_d = ST_INPUT;
`ifdef GAME_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end else begin
          show_d = show_q + SW'(1);
        end
      end
      ST_INPUT: begin
        if (press != '0) begin
          if (press == exp_onehot) begin
            cc_d  = cc_q + 8'd1;
            idx_d = idx_q + 8'd1;
`ifdef GAME_TIMEOUT_EN
            tmo_d = '0;
`endif
            if (idx_q + 8'd1 == level_q) begin
              state_d = ST_LVL_DONE;
            end
          end else begin
            state_d = ST_LOSE;
          end
        end else begin
`ifdef GAME_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            state_d = ST_LOSE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
`endif
        end
      end
      ST_LVL_DONE: begin
        if (level_q == MAX_LVL) begin
          state_d = ST_WIN;
        end else begin
          level_d = level_q + 8'd1;
          idx_d   = '0;
          cc_d    = '0;
          show_d  = '0;
          state_d = ST_SHOW_ON;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign led           = (state_q == ST_SHOW_ON) ? exp_onehot : '0;
  assign busy          = !((state_q == ST_IDLE) || (state_q == ST_WIN) || (state_q == ST_LOSE));
  assign level         = level_q;
  assign correct_count = cc_q;
  assign win           = (state_q == ST_WIN);
  assign lose          = (state_q == ST_LOSE);

endmodule

// File: tb/tb_simon_sequence_game.sv
// Directed bench for simon_sequence_game (4 buttons, 3 levels, 4-cycle
// playback). Symbol expectations come from a local model of the LFSR.
// The timeout sequence is compiled in only with GAME_TIMEOUT_EN.
module tb_simon_sequence_game;

  localparam int NB = 4;
  localparam int ML = 3;
  localparam int SC = 4;
  localparam int TC = 50;
  localparam logic [7:0] SEED = 8'h5A;

  logic       oscClk = 1'b0;
  logic       reset  = 1'b1;
  logic       start  = 1'b0;
  logic [3:0] button = 4'b0;
  logic [3:0] led;
  logic       busy;
  logic [7:0] level;
  logic [7:0] correctCount;
  logic       win;
  logic       lose;

  int checks   = 0;
  int failures = 0;

  logic [7:0] modelLfsr;
  logic [1:0] sym [ML];

  typedef struct {
    string      name;
    logic       start;
    logic [3:0] button;
    logic [3:0] led;
    logic       busy;
    logic [7:0] level;
    logic [7:0] cc;
    logic       win;
    logic       lose;
  } vec_t;

  vec_t vecs[$];

  simon_sequence_game #(
    .N_BUTTONS  (NB),
    .MAX_LEN    (ML),
    .SHOW_CYCLES(SC),
    .TIMEOUT_CYC(TC),
    .LFSR_SEED  (SEED)
  ) dut (
    .osc_clk      (oscClk),
    .reset        (reset),
    .start        (start),
    .button       (button),
    .led          (led),
    .busy         (busy),
    .level        (level),
    .correct_count(correctCount),
    .win          (win),
    .lose         (lose)
  );

  // Free-running clock, period 10.
  always #5 oscClk = ~oscClk;

  function automatic logic [7:0] stepLfsr(input logic [7:0] v);
    if (v[0]) return (v >> 1) ^ 8'hB8;
    return v >> 1;
  endfunction

  function automatic logic [3:0] oneHot(input logic [1:0] s);
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
  endfunction

  // Reference LFSR advancing on the same edges as the design's.
  always @(posedge oscClk) begin
    modelLfsr <= reset ? SEED : stepLfsr(modelLfsr);
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required done", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(posedge oscClk);
    @(negedge oscClk);
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] b);
    start  = s;
    button = b;
    stepCycle();
    start  = 1'b0;
    button = 4'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eLed, input logic eBusy,
                             input logic [7:0] eLevel, input logic [7:0] eCc,
                             input logic eWin, input logic eLose);
    checks++;
    if ({led, busy, level, correctCount, win, lose} !== {eLed, eBusy, eLevel, eCc, eWin, eLose}) begin
      failures++;
      $display("[TB] FAIL %s: got led=%b busy=%b level=%0d cc=%0d win=%b lose=%b, expected led=%b busy=%b level=%0d cc=%0d win=%b lose=%b",
               name, led, busy, level, correctCount, win, lose, eLed, eBusy, eLevel, eCc, eWin, eLose);
    end
  endtask

  // Called in the cycle start is applied: GEN cycle j stores the LFSR value j+1 steps ahead.
  task automatic predictSymbols();
    logic [7:0] l;
    l = modelLfsr;
    for (int j = 0; j < ML; j++) begin
      l = stepLfsr(l);
      sym[j] = l[1:0];
    end
  endtask

  task automatic startGame();
    predictSymbols();
    applyStimulus(1'b1, 4'b0);
    repeat (ML) stepCycle();
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 1'b0;
    button = 4'b0;
    repeat (2) stepCycle();
    reset = 1'b0;
  endtask

  task automatic addVec(input string n, input logic s, input logic [3:0] b, input logic [3:0] l,
                        input logic bz, input logic [7:0] lv, input logic [7:0] c,
                        input logic w, input logic lo);
    vec_t v;
    v.name = n; v.start = s; v.button = b; v.led = l; v.busy = bz;
    v.level = lv; v.cc = c; v.win = w; v.lose = lo;
    vecs.push_back(v);
  endtask

  task automatic buildGameTable();
    addVec("start", 1'b1, 4'b0, 4'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    for (int g = 0; g < ML; g++) addVec("gen", 1'b0, 4'b0, 4'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    for (int k = 1; k <= ML; k++) begin
      for (int i = 0; i < k; i++) begin
        repeat (SC) addVec("show_on", 1'b0, 4'b0, oneHot(sym[i]), 1'b1, 8'(k), 8'd0, 1'b0, 1'b0);
        repeat (SC) addVec("show_off", 1'b0, 4'b0, 4'b0, 1'b1, 8'(k), 8'd0, 1'b0, 1'b0);
      end
      for (int i = 0; i < k; i++) begin
        addVec("press", 1'b0, oneHot(sym[i]), 4'b0, 1'b1, 8'(k), 8'(i), 1'b0, 1'b0);
        if (i < k - 1) addVec("release", 1'b0, 4'b0, 4'b0, 1'b1, 8'(k), 8'(i + 1), 1'b0, 1'b0);
      end
      addVec("lvl_done", 1'b0, 4'b0, 4'b0, 1'b1, 8'(k), 8'(k), 1'b0, 1'b0);
    end
    addVec("win_restart", 1'b1, 4'b0, 4'b0, 1'b0, 8'd3, 8'd3, 1'b1, 1'b0);
    addVec("regen", 1'b0, 4'b0, 4'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] twoBtn;
    logic [1:0] wrongSym;
    logic [1:0] nextSym;

    // Reset and start-during-reset.
    @(negedge oscClk);
    repeat (2) stepCycle();
    checkOutput("reset", 4'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("start_in_reset", 4'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    stepCycle();
    checkOutput("idle_after_reset", 4'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Full winning game, cycle by cycle, then restart from WIN.
    predictSymbols();
    buildGameTable();
    for (int i = 0; i < vecs.size(); i++) begin
      checkOutput(vecs[i].name, vecs[i].led, vecs[i].busy, vecs[i].level,
                  vecs[i].cc, vecs[i].win, vecs[i].lose);
      applyStimulus(vecs[i].start, vecs[i].button);
    end

    // Level 2, second symbol wrong.
    doReset();
    startGame();
    repeat (2 * SC) stepCycle();
    applyStimulus(1'b0, oneHot(sym[0]));
    checkOutput("t4_l1_done", 4'b0, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    stepCycle();
    repeat (4 * SC) stepCycle();
    applyStimulus(1'b0, oneHot(sym[0]));
    checkOutput("t4_l2_first", 4'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0);
    stepCycle();
    wrongSym = sym[1] + 2'd1;
    applyStimulus(1'b0, oneHot(wrongSym));
    checkOutput("t4_wrong", 4'b0, 1'b0, 8'd2, 8'd1, 1'b0, 1'b1);

    // From LOSE: presses and start during playback are ignored; two edges lose.
    startGame();
    checkOutput("t5_show", oneHot(sym[0]), 1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, oneHot(sym[0]));
    stepCycle();
    applyStimulus(1'b1, 4'b0);
    checkOutput("t5_start_ignored", oneHot(sym[0]), 1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
    repeat (5) stepCycle();
    checkOutput("t5_input_cc0", 4'b0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
    nextSym = sym[0] + 2'd1;
    twoBtn = oneHot(sym[0]) | oneHot(nextSym);
    applyStimulus(1'b0, twoBtn);
    checkOutput("t5_two_edges", 4'b0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b1);

`ifdef GAME_TIMEOUT_EN
    // Press in the last allowed cycle is accepted; a full idle window loses.
    doReset();
    startGame();
    repeat (2 * SC) stepCycle();
    repeat (TC - 1) stepCycle();
    checkOutput("t6_wait49", 4'b0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, oneHot(sym[0]));
    checkOutput("t6_press49", 4'b0, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    stepCycle();
    repeat (4 * SC) stepCycle();
    repeat (TC - 1) stepCycle();
    checkOutput("t6_idle49", 4'b0, 1'b1, 8'd2, 8'd0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("t6_timeout", 4'b0, 1'b0, 8'd2, 8'd0, 1'b0, 1'b1);
`endif

    // Mid-game reset aborts straight back to IDLE.
    doReset();
    startGame();
    repeat (2) stepCycle();
    checkOutput("pre_abort", oneHot(sym[0]), 1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
    reset = 1'b1;
    stepCycle();
    checkOutput("midgame_reset", 4'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    stepCycle();
    checkOutput("idle_after_abort", 4'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
